// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART AXIS arbitration blocks.
// Holds the arbiter state enum, default sizes and an index-width helper.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PASS  = 2'd1,
    ST_GUARD = 2'd2
  } arb_state_t;

  localparam int DEF_NUM_SRC = 4;
  localparam int DEF_GUARD_W = 16;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: searches req from last_grant+1 upward.
// Ports: req (N), last_grant (index), grant (one-hot, 0 when no request).
module rr_picker
  import uart_pkg::*;
#(
  parameter int N  = DEF_NUM_SRC,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [N-1:0]  grant
);

  logic [IW-1:0] idx;
  logic          hit;

  always_comb begin
    grant = '0;
    hit   = 1'b0;
    idx   = '0;
    for (int i = 1; i <= N; i++) begin
      idx = IW'((int'(last_grant) + i) % N);
      if (!hit && req[idx]) begin
        grant[idx] = 1'b1;
        hit        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_uart_tx_arb.sv
// Round-robin AXIS byte arbiter feeding one UART transmitter.
// Ports: clk/rst_n, saxis_* per-source bytes, maxis_* to UART, arb_enable,
// guard_cycles idle gap after packets, grant_o one-hot owner, busy_o.
module axis_uart_tx_arb
  import uart_pkg::*;
#(
  parameter int NUM_SRC = DEF_NUM_SRC,
  parameter int GUARD_W = DEF_GUARD_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_SRC*8-1:0] saxis_data_i,
  input  logic [NUM_SRC-1:0]   saxis_tvalid_i,
  input  logic [NUM_SRC-1:0]   saxis_tlast_i,
  output logic [NUM_SRC-1:0]   saxis_tready_o,
  output logic [7:0]           maxis_data_o,
  output logic                 maxis_tvalid_o,
  input  logic                 maxis_tready_i,
  input  logic                 arb_enable,
  input  logic [GUARD_W-1:0]   guard_cycles,
  output logic [NUM_SRC-1:0]   grant_o,
  output logic                 busy_o
);

  localparam int IW = idx_w(NUM_SRC);

  arb_state_t         state_q, state_d;
  logic [NUM_SRC-1:0] grant_q, grant_d;
  logic [NUM_SRC-1:0] pick;
  logic [IW-1:0]      gidx_q, gidx_d;
  logic [IW-1:0]      last_q, last_d;
  logic [IW-1:0]      pick_idx;
  logic [GUARD_W-1:0] cnt_q, cnt_d;

  logic       in_pass;
  logic       hs;
  logic [7:0] sel_data;
  logic       sel_valid;
  logic       sel_last;

  rr_picker #(
    .N (NUM_SRC),
    .IW(IW)
  ) u_pick (
    .req       (saxis_tvalid_i),
    .last_grant(last_q),
    .grant     (pick)
  );

  always_comb begin
    pick_idx = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (pick[k]) pick_idx = IW'(k);
    end
  end

  // grant_q is one-hot or zero, so an OR-style select is enough
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (grant_q[k]) begin
        sel_data  = saxis_data_i[8*k +: 8];
        sel_valid = saxis_tvalid_i[k];
        sel_last  = saxis_tlast_i[k];
      end
    end
  end

  assign in_pass = (state_q == ST_PASS);

  assign maxis_data_o   = in_pass ? sel_data : 8'h00;
  assign maxis_tvalid_o = in_pass & sel_valid;
  assign saxis_tready_o = (in_pass && maxis_tready_i)
                          ? grant_q : '0;
  assign hs             = maxis_tvalid_o & maxis_tready_i;

  assign grant_o = grant_q;
  assign busy_o  = (state_q != ST_IDLE);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_enable && |saxis_tvalid_i) begin
          state_d = ST_PASS;
          grant_d = pick;
          gidx_d  = pick_idx;
        end
      end
      ST_PASS: begin
        if (hs && sel_last) begin
          last_d  = gidx_q;
          grant_d = '0;
          if (guard_cycles == '0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_GUARD;
            cnt_d   = guard_cycles;
          end
        end
      end
      ST_GUARD: begin
        // counter was loaded with the gap length; leave on its last clock
        if (cnt_q <= GUARD_W'(1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - GUARD_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      last_q  <= IW'(NUM_SRC - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_axis_uart_tx_arb.sv
// Directed self-checking bench for axis_uart_tx_arb (4 sources).
// Drives sources by hand one clock at a time and checks every output.
module tb_axis_uart_tx_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  sd [4];
  logic [31:0] data_i;
  logic [3:0]  tv, tl, tr, gr;
  logic [7:0]  md;
  logic        mv, mr, en, busy;
  logic [15:0] gc;

  int checks = 0;
  int fails  = 0;
  int ord [5] = '{0, 1, 2, 3, 0};

  assign data_i = {sd[3], sd[2], sd[1], sd[0]};

  always #5 clk = ~clk;

  axis_uart_tx_arb #(
    .NUM_SRC(4),
    .GUARD_W(16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .saxis_data_i  (data_i),
    .saxis_tvalid_i(tv),
    .saxis_tlast_i (tl),
    .saxis_tready_o(tr),
    .maxis_data_o  (md),
    .maxis_tvalid_o(mv),
    .maxis_tready_i(mr),
    .arb_enable    (en),
    .guard_cycles  (gc),
    .grant_o       (gr),
    .busy_o        (busy)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_srcs();
    tv = '0;
    tl = '0;
    for (int k = 0; k < 4; k++) sd[k] = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    idle_srcs();
    en    = 1'b1;
    mr    = 1'b1;
    gc    = '0;
    rst_n = 1'b0;

    // reset state, with a request already present
    tv    = 4'b0100;
    sd[2] = 8'hA1;
    tick();
    #1;
    chk("rst_grant", 32'(gr), 32'h0);
    chk("rst_busy",  32'(busy), 32'h0);
    chk("rst_mv",    32'(mv), 32'h0);
    chk("rst_tr",    32'(tr), 32'h0);
    chk("rst_md",    32'(md), 32'h0);
    rst_n = 1'b1;

    // source 2, 3-byte packet, guard 0
    tick();
    #1;
    chk("t1_grant", 32'(gr), 32'h4);
    chk("t1_d0",    32'(md), 32'hA1);
    chk("t1_tr",    32'(tr), 32'h4);
    tick();
    sd[2] = 8'hA2;
    #1;
    chk("t1_d1", 32'(md), 32'hA2);
    tick();
    sd[2] = 8'hA3;
    tl[2] = 1'b1;
    #1;
    chk("t1_d2", 32'(md), 32'hA3);
    chk("t1_mv", 32'(mv), 32'h1);
    tick();
    idle_srcs();
    #1;
    chk("t1_idle_busy",  32'(busy), 32'h0);
    chk("t1_idle_grant", 32'(gr), 32'h0);

    // all sources, 1-byte packets back to back
    do_reset();
    tv = 4'hF;
    tl = 4'hF;
    for (int k = 0; k < 4; k++) sd[k] = 8'(16 + k);
    for (int i = 0; i < 5; i++) begin
      tick();
      #1;
      chk("t2_grant", 32'(gr), 32'(1 << ord[i]));
      chk("t2_data",  32'(md), 32'(16 + ord[i]));
      tick();
      #1;
      chk("t2_idle", 32'(busy), 32'h0);
    end
    idle_srcs();

    // guard of 5 clocks; changing guard_cycles mid-guard has no effect
    gc    = 16'd5;
    tv[1] = 1'b1;
    tl[1] = 1'b1;
    sd[1] = 8'h55;
    tv[3] = 1'b1;
    tl[3] = 1'b1;
    sd[3] = 8'h77;
    tick();
    #1;
    chk("t3_grant", 32'(gr), 32'h2);
    chk("t3_data",  32'(md), 32'h55);
    tick();
    tv[1] = 1'b0;
    gc    = '0;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("t3_busy",  32'(busy), 32'h1);
      chk("t3_mv",    32'(mv), 32'h0);
      chk("t3_grant0", 32'(gr), 32'h0);
      chk("t3_tr",    32'(tr), 32'h0);
      tick();
      #1;
    end
    chk("t3_end_busy",  32'(busy), 32'h0);
    chk("t3_end_grant", 32'(gr), 32'h0);
    tick();
    #1;
    chk("t3_next_grant", 32'(gr), 32'h8);
    chk("t3_next_data",  32'(md), 32'h77);
    tick();
    idle_srcs();
    #1;
    chk("t3_idle", 32'(busy), 32'h0);

    // downstream stall 10 clocks mid-packet, source 1 waiting
    tv[0] = 1'b1;
    tl[0] = 1'b0;
    sd[0] = 8'hB0;
    tv[1] = 1'b1;
    tl[1] = 1'b1;
    sd[1] = 8'hC0;
    tick();
    #1;
    chk("t4_grant", 32'(gr), 32'h1);
    chk("t4_d0",    32'(md), 32'hB0);
    tick();
    sd[0] = 8'hB1;
    tl[0] = 1'b1;
    mr    = 1'b0;
    #1;
    for (int i = 0; i < 10; i++) begin
      chk("t4_hold_grant", 32'(gr), 32'h1);
      chk("t4_hold_data",  32'(md), 32'hB1);
      chk("t4_hold_mv",    32'(mv), 32'h1);
      chk("t4_hold_tr",    32'(tr), 32'h0);
      tick();
      #1;
    end
    mr = 1'b1;
    #1;
    chk("t4_tr", 32'(tr), 32'h1);
    tick();
    tv[0] = 1'b0;
    tl[0] = 1'b0;
    #1;
    chk("t4_idle", 32'(busy), 32'h0);
    tick();
    #1;
    chk("t4_src1_grant", 32'(gr), 32'h2);
    chk("t4_src1_data",  32'(md), 32'hC0);
    tick();
    idle_srcs();
    #1;
    chk("t4_done", 32'(busy), 32'h0);

    // arb_enable dropped on byte 2 of 4
    tv[2] = 1'b1;
    sd[2] = 8'hD0;
    tick();
    #1;
    chk("t5_grant", 32'(gr), 32'h4);
    chk("t5_d0",    32'(md), 32'hD0);
    tick();
    sd[2] = 8'hD1;
    en    = 1'b0;
    #1;
    chk("t5_d1",     32'(md), 32'hD1);
    chk("t5_keep",   32'(gr), 32'h4);
    tick();
    sd[2] = 8'hD2;
    #1;
    chk("t5_d2", 32'(md), 32'hD2);
    tick();
    sd[2] = 8'hD3;
    tl[2] = 1'b1;
    #1;
    chk("t5_d3", 32'(md), 32'hD3);
    chk("t5_mv", 32'(mv), 32'h1);
    tick();
    tv[2] = 1'b0;
    tl[2] = 1'b0;
    tv[0] = 1'b1;
    tl[0] = 1'b1;
    sd[0] = 8'hE0;
    #1;
    chk("t5_done", 32'(busy), 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      #1;
      chk("t5_blocked_grant", 32'(gr), 32'h0);
      chk("t5_blocked_busy",  32'(busy), 32'h0);
    end
    en = 1'b1;
    tick();
    #1;
    chk("t5_resume_grant", 32'(gr), 32'h1);
    chk("t5_resume_data",  32'(md), 32'hE0);
    tick();
    idle_srcs();
    #1;
    chk("t5_idle", 32'(busy), 32'h0);

    // reset mid-packet, then source 0 has priority
    tv[1] = 1'b1;
    tl[1] = 1'b0;
    sd[1] = 8'h61;
    tv[0] = 1'b1;
    tl[0] = 1'b1;
    sd[0] = 8'h60;
    tick();
    #1;
    chk("t6_grant", 32'(gr), 32'h2);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_grant", 32'(gr), 32'h0);
    chk("t6_rst_busy",  32'(busy), 32'h0);
    chk("t6_rst_mv",    32'(mv), 32'h0);
    chk("t6_rst_tr",    32'(tr), 32'h0);
    chk("t6_rst_md",    32'(md), 32'h0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("t6_post_busy", 32'(busy), 32'h0);
    tick();
    #1;
    chk("t6_prio_grant", 32'(gr), 32'h1);
    chk("t6_prio_data",  32'(md), 32'h60);
    tick();
    idle_srcs();
    #1;
    chk("t6_idle", 32'(busy), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/axis_uart_tx_arb.md
AXIS_UART_TX_ARB -- requirements
Module: axis_uart_tx_arb

Interface
REQ-001 The block SHALL have parameter NUM_SRC, default 4, meaning the number of AXIS byte requesters (2..8).
REQ-002 The block SHALL have parameter GUARD_W, default 16, meaning the width of the inter-packet guard counter.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low; ports are named clk and rst_n.
REQ-004 The block SHALL have port clk, input, 1 bit, meaning the single clock for all state.
REQ-005 The block SHALL have port rst_n, input, 1 bit, meaning the asynchronous active-low reset.
REQ-006 The block SHALL have port saxis_data_i, input, NUM_SRC*8 bits, meaning the per-source bytes (source k at [8k+7:8k]).
REQ-007 The block SHALL have port saxis_tvalid_i, input, NUM_SRC bits, meaning the per-source valid.
REQ-008 The block SHALL have port saxis_tlast_i, input, NUM_SRC bits, meaning the per-source last byte of a packet.
REQ-009 The block SHALL have port saxis_tready_o, output, NUM_SRC bits, meaning the per-source ready.
REQ-010 The block SHALL have port maxis_data_o, output, 8 bits, meaning the byte to the UART transmitter.
REQ-011 The block SHALL have port maxis_tvalid_o, output, 1 bit, meaning valid to the UART transmitter.
REQ-012 The block SHALL have port maxis_tready_i, input, 1 bit, meaning ready from the UART transmitter.
REQ-013 The block SHALL have port arb_enable, input, 1 bit, meaning the APB-register enable for new grants.
REQ-014 The block SHALL have port guard_cycles, input, GUARD_W bits, meaning the APB-register idle clocks after each packet.
REQ-015 The block SHALL have port grant_o, output, NUM_SRC bits, meaning the one-hot current owner (0 when none).
REQ-016 The block SHALL have port busy_o, output, 1 bit, meaning the state is not IDLE.

Function
REQ-017 The block SHALL use the states IDLE, PASS and GUARD.
REQ-018 In IDLE, when arb_enable=1 and any saxis_tvalid_i bit is set, the block SHALL pick a source round-robin, searching from (last_grant+1) mod NUM_SRC upward, register it in grant_o and enter PASS on the next edge.
REQ-019 In IDLE with arb_enable=0, the block SHALL make no grant, whatever the request state.
REQ-020 In PASS, the granted source's data and tvalid SHALL drive maxis_* combinationally, and saxis_tready_o[grant]=maxis_tready_i; all other ready bits SHALL be 0.
REQ-021 Outside PASS, maxis_tvalid_o SHALL be 0 and every saxis_tready_o bit SHALL be 0.
REQ-022 Ownership SHALL be held until a handshake (tvalid&tready) with tlast=1; gaps in tvalid inside a packet SHALL NOT release the grant.
REQ-023 Deasserting arb_enable mid-packet SHALL NOT abort the packet; it only blocks the next grant.
REQ-024 On the tlast handshake, the block SHALL copy the grant index into last_grant, clear grant_o, and go to GUARD with the counter loaded from guard_cycles; if guard_cycles=0 it SHALL go straight to IDLE.
REQ-025 GUARD SHALL last exactly guard_cycles clocks, then the block SHALL return to IDLE; guard_cycles changes during GUARD SHALL NOT affect the running count.
REQ-026 Arbitration latency SHALL be 1 clock from request seen in IDLE to the first possible transfer.
REQ-027 When only one source requests, it SHALL be granted repeatedly, separated only by guard and the 1-cycle IDLE.
REQ-028 The maxis_* outputs SHALL follow AXIS rules: once valid, data SHALL stay stable until tready.

Reset
REQ-029 During reset, state=IDLE, grant_o=0, busy_o=0, maxis_tvalid_o=0, saxis_tready_o=0, maxis_data_o=0, guard counter=0, and last_grant=NUM_SRC-1 so that source 0 wins first.
REQ-030 Reset asserted mid-packet SHALL drop the packet immediately; after release the block SHALL start in IDLE with no grant.

Structure
REQ-031 The state enum arb_state_t and the default constants SHALL live in the shared package uart_pkg.
REQ-032 The round-robin search SHALL be the combinational sub-module rr_picker (inputs req, last_grant; output one-hot grant), reusable by the RX side.

Verification
REQ-033 The bench SHALL cover: reset release, then source 2 sends a 3-byte packet with guard=0 -> grant_o=4'b0100 after 1 clock, 3 bytes out, IDLE on the next edge.
REQ-034 The bench SHALL cover: all 4 sources request 1-byte packets continuously -> grant order 0,1,2,3,0.
REQ-035 The bench SHALL cover: guard_cycles=5 -> busy_o high and maxis_tvalid_o low for exactly 5 clocks after tlast.
REQ-036 The bench SHALL cover: maxis_tready_i low for 10 clocks mid-packet, and source 1 requesting meanwhile -> the grant stays on source 0 and the data stays stable.
REQ-037 The bench SHALL cover: arb_enable dropped on byte 2 of 4 -> all 4 bytes complete, then no grant until arb_enable=1.
REQ-038 The bench SHALL cover: rst_n asserted mid-packet -> all outputs 0 at once; after release, source 0 has priority.
